uart_sram_tx_interface: RTL



---
 rtl/uart_tx_pkg.sv | 22 ++
 rtl/uart_byte_tx.sv | 73 +++++++
 rtl/uart_sram_tx_interface.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Purpose: shared types and frame geometry for the SRAM-to-UART transmit path.
// Latency: n/a (package).
// Backpressure: n/a (package).
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit, 11-bit frames).
package uart_tx_pkg;

    typedef enum logic [2:0] {
        S_TX_IDLE,
        S_TX_REQ,
        S_TX_WAIT,
        S_TX_BYTE,
        S_TX_DONE
    } tx_state_type;

    // Bits per UART frame: start + 8 data (+ parity) + stop.
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_byte_tx.sv
// Purpose: serialise one byte as a UART frame, LSB first, line driven from a flop.
// Latency: start bit on the line the cycle after Load; frame lasts FRAME_BITS*BAUD_DIV cycles.
// Backpressure: none; Load restarts the frame, and the owner reloads on Tx_done for back-to-back frames.
//
// Ports: Clock, Resetn (sync, active low), Load + Data[7:0] start a frame,
//        TX serial line (idles high), Tx_done high in the final cycle of the stop bit.
// Optional feature macro: UART_TX_PARITY_EN (even parity between d7 and stop).
module uart_byte_tx
    import uart_tx_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Load,
    input  logic [7:0] Data,
    output logic       TX,
    output logic       Tx_done
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [FRAME_BITS-1:0] shift_q;
    logic [FRAME_BITS-1:0] frame;
    logic [BW-1:0]         baud_q;
    logic [3:0]            bit_q;
    logic                  active_q;
    logic                  baud_end;

    always_comb begin
`ifdef UART_TX_PARITY_EN
        frame = {1'b1, ^Data, Data, 1'b0};
`else
        frame = {1'b1, Data, 1'b0};
`endif
    end

    assign baud_end = active_q && (baud_q == BW'(BAUD_DIV - 1));
    // Combinational so the owner can reload on this same edge with no idle gap.
    assign Tx_done  = baud_end && (bit_q == 4'(FRAME_BITS - 1));

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            shift_q  <= '1;
            baud_q   <= '0;
            bit_q    <= '0;
            active_q <= 1'b0;
        end else if (Load) begin
            shift_q  <= frame;
            baud_q   <= '0;
            bit_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (baud_end) begin
                baud_q  <= '0;
                // Ones shift in behind the stop bit, leaving the line idle-high.
                shift_q <= {1'b1, shift_q[FRAME_BITS-1:1]};
                if (bit_q == 4'(FRAME_BITS - 1)) begin
                    bit_q    <= '0;
                    active_q <= 1'b0;
                end else begin
                    bit_q <= bit_q + 4'd1;
                end
            end else begin
                baud_q <= baud_q + BW'(1);
            end
        end
    end

    // Bit 0 of the shift register is the line itself: a flop output, glitch-free.
    assign TX = shift_q[0];

endmodule

// File: rtl/uart_sram_tx_interface.sv
// Purpose: read a block of 16-bit SRAM words and send each as two UART frames, high byte first.
// Latency: first start bit SRAM_RD_LAT+2 cycles after Start; SRAM_RD_LAT+1 idle cycles between words.
// Backpressure: none; Start is only sampled in idle and dropped while Busy or in the Done cycle.
//
// Ports: Clock, Resetn (sync, active low), Start/Base_address/Word_count launch a block,
//        SRAM_address/SRAM_read_data/SRAM_we_n read-only SRAM port, UART_TX_O serial line,
//        Busy while transferring, Done one-cycle pulse after the last stop bit.
// Optional feature macro: UART_TX_PARITY_EN (even-parity frames, see uart_byte_tx).
module uart_sram_tx_interface
    import uart_tx_pkg::*;
#(
    parameter int BAUD_DIV    = 434,
    parameter int SRAM_RD_LAT = 2
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Start,
    input  logic [17:0] Base_address,
    input  logic [17:0] Word_count,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic        SRAM_we_n,
    output logic        UART_TX_O,
    output logic        Busy,
    output logic        Done
);

    localparam int WW = (SRAM_RD_LAT > 1) ? $clog2(SRAM_RD_LAT) : 1;

    tx_state_type state, state_n;

    logic [17:0]   addr_q;
    logic [17:0]   rem_q;
    logic [17:0]   sram_addr_q;
    logic [7:0]    word_lo_q;
    logic          byte_sel_q;
    logic [WW-1:0] wait_cnt_q;
    logic          wait_last;

    logic          byte_load;
    logic [7:0]    byte_dat;
    logic          byte_done;

    assign wait_last = (wait_cnt_q == WW'(SRAM_RD_LAT - 1));

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= S_TX_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        byte_load = 1'b0;
        byte_dat  = SRAM_read_data[15:8];
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            S_TX_IDLE: begin
                if (Start) begin
                    state_n = (Word_count == '0) ? S_TX_DONE : S_TX_REQ;
                end
            end
            S_TX_REQ: begin
                Busy    = 1'b1;
                state_n = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                Busy = 1'b1;
                // High byte goes straight from the SRAM bus into the shifter on the
                // capture edge, so the start bit follows the read with no extra cycle.
                if (wait_last) begin
                    byte_load = 1'b1;
                    byte_dat  = SRAM_read_data[15:8];
                    state_n   = S_TX_BYTE;
                end
            end
            S_TX_BYTE: begin
                Busy = 1'b1;
                if (byte_done) begin
                    if (!byte_sel_q) begin
                        byte_load = 1'b1;
                        byte_dat  = word_lo_q;
                    end else if (rem_q == 18'd1) begin
                        state_n = S_TX_DONE;
                    end else begin
                        state_n = S_TX_REQ;
                    end
                end
            end
            S_TX_DONE: begin
                Done    = 1'b1;
                state_n = S_TX_IDLE;
            end
            default: state_n = S_TX_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            addr_q      <= '0;
            rem_q       <= '0;
            sram_addr_q <= '0;
            word_lo_q   <= '0;
            byte_sel_q  <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            case (state)
                S_TX_IDLE: begin
                    if (Start) begin
                        addr_q <= Base_address;
                        rem_q  <= Word_count;
                        // A zero-length block never touches the SRAM port.
                        if (Word_count != '0) begin
                            sram_addr_q <= Base_address;
                        end
                    end
                end
                S_TX_REQ: begin
                    wait_cnt_q <= '0;
                end
                S_TX_WAIT: begin
                    if (wait_last) begin
                        word_lo_q  <= SRAM_read_data[7:0];
                        byte_sel_q <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WW'(1);
                    end
                end
                S_TX_BYTE: begin
                    if (byte_done) begin
                        if (!byte_sel_q) begin
                            byte_sel_q <= 1'b1;
                        end else begin
                            // 18-bit add wraps 3FFFF -> 00000 naturally.
                            addr_q <= addr_q + 18'd1;
                            rem_q  <= rem_q - 18'd1;
                            if (rem_q != 18'd1) begin
                                sram_addr_q <= addr_q + 18'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    uart_byte_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_byte_tx (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Load    (byte_load),
        .Data    (byte_dat),
        .TX      (UART_TX_O),
        .Tx_done (byte_done)
    );

    assign SRAM_address = sram_addr_q;
    assign SRAM_we_n    = 1'b1;

endmodule
